// File: rtl/acc_cache_downstream_if.sv
// Client, downstream-memory and flush signals of the accumulator cache.
// The cache itself uses the slave view and a driver uses the master view.
interface acc_cache_downstream_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned WORDS  = 4,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned LINE_W = DATA_W * WORDS;

    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              mem_req_valid;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_data;
    logic              mem_rsp_ready;
    logic [LINE_W-1:0] mem_rsp_data;
    logic              flush_req;
    logic              flush_busy;
    logic              ovf;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, mem_rsp_ready, mem_rsp_data, flush_req,
        output req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_rw, mem_req_addr,
               mem_req_data, flush_busy, ovf
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, mem_rsp_ready, mem_rsp_data, flush_req,
        input  req_ready, rsp_valid, rsp_data, mem_req_valid, mem_req_rw, mem_req_addr,
               mem_req_data, flush_busy, ovf
    );
endinterface

// File: rtl/acc_cache_downstream.sv
// Direct-mapped write-back accumulator cache in front of a line-wide downstream memory.
// One request in flight; a miss writes back a dirty victim, then fills, then re-compares.
module acc_cache_downstream #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned WORDS    = 4,
    parameter int unsigned LINES    = 1024,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned SATURATE = 0
) (
    input logic                   clk,
    input logic                   rst,
    acc_cache_downstream_if.slave bus
);
    localparam int unsigned LINE_W = DATA_W * WORDS;
    localparam int unsigned BYTE_B = $clog2(DATA_W / 8);
    localparam int unsigned OFS    = $clog2(LINE_W / 8);
    localparam int unsigned IDX    = $clog2(LINES);
    localparam int unsigned TAG    = ADDR_W - IDX - OFS;
    localparam int unsigned WSEL   = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [2:0] {StIdle, StCompare, StWriteBack, StAllocate, StFlush} state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;
    logic [IDX-1:0]    fidx_q, fidx_d;
    logic              fpend_q, fpend_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              mreq_valid_q, mreq_valid_d;
    logic              mreq_rw_q, mreq_rw_d;
    logic [ADDR_W-1:0] mreq_addr_q, mreq_addr_d;
    logic [LINE_W-1:0] mreq_data_q, mreq_data_d;

    logic [TAG-1:0]    tag_mem  [LINES];
    logic [LINE_W-1:0] data_mem [LINES];

    logic [IDX-1:0]    req_idx;
    logic [TAG-1:0]    req_tag;
    logic [WSEL-1:0]   word_sel;
    logic [LINE_W-1:0] cur_line, upd_line, wr_line;
    logic [DATA_W-1:0] cur_word, new_word;
    logic [DATA_W:0]   sum;
    logic              hit, wr_en, tag_wr, flush_step;
    logic [IDX-1:0]    wr_idx;
    logic [ADDR_W-1:0] fill_addr, victim_addr, flush_addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    assign req_idx     = addr_q[OFS +: IDX];
    assign req_tag     = addr_q[OFS+IDX +: TAG];
    assign cur_line    = data_mem[req_idx];
    assign cur_word    = cur_line[word_sel*DATA_W +: DATA_W];
    assign hit         = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    assign fill_addr   = {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}};
    assign victim_addr = {tag_mem[req_idx], req_idx, {OFS{1'b0}}};
    assign flush_addr  = {tag_mem[fidx_q], fidx_q, {OFS{1'b0}}};

    generate
        if (WORDS > 1) begin : g_wsel
            assign word_sel = addr_q[BYTE_B +: WSEL];
        end else begin : g_nowsel
            assign word_sel = '0;
        end
        if (BYTE_B > 0) begin : g_byte_bits
            logic unused_byte_bits;
            assign unused_byte_bits = ^addr_q[BYTE_B-1:0];
        end
    endgenerate

    // Carry out of the widened sum is the overflow condition for both modes.
    always_comb begin
        sum = {1'b0, cur_word} + {1'b0, data_q};
        case (op_q)
            2'b01:   new_word = (sum[DATA_W] && (SATURATE != 0)) ? '1 : sum[DATA_W-1:0];
            2'b10:   new_word = '0;
            2'b11:   new_word = data_q;
            default: new_word = cur_word;
        endcase
        upd_line = cur_line;
        upd_line[word_sel*DATA_W +: DATA_W] = new_word;
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        data_d       = data_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        fidx_d       = fidx_q;
        fpend_d      = fpend_q | bus.flush_req;
        ovf_d        = ovf_q;
        rsp_data_d   = rsp_data_q;
        mreq_valid_d = mreq_valid_q;
        mreq_rw_d    = mreq_rw_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_data_d  = mreq_data_q;
        rsp_valid    = 1'b0;
        rsp_data     = rsp_data_q;
        wr_en        = 1'b0;
        wr_idx       = req_idx;
        wr_line      = upd_line;
        tag_wr       = 1'b0;
        flush_step   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fpend_q || bus.flush_req) begin
                    fpend_d = 1'b0;
                    fidx_d  = '0;
                    state_d = StFlush;
                end else if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_data;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    rsp_valid  = 1'b1;
                    rsp_data   = cur_word;
                    rsp_data_d = cur_word;
                    if (op_q != 2'b00) begin
                        wr_en            = 1'b1;
                        dirty_d[req_idx] = 1'b1;
                    end
                    if (op_q == 2'b01 && sum[DATA_W]) begin
                        ovf_d = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    mreq_valid_d = 1'b1;
                    if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        mreq_rw_d   = 1'b1;
                        mreq_addr_d = victim_addr;
                        mreq_data_d = cur_line;
                        state_d     = StWriteBack;
                    end else begin
                        mreq_rw_d   = 1'b0;
                        mreq_addr_d = fill_addr;
                        state_d     = StAllocate;
                    end
                end
            end
            StWriteBack: begin
                if (bus.mem_rsp_ready) begin
                    mreq_rw_d   = 1'b0;
                    mreq_addr_d = fill_addr;
                    state_d     = StAllocate;
                end
            end
            StAllocate: begin
                if (bus.mem_rsp_ready) begin
                    mreq_valid_d     = 1'b0;
                    wr_en            = 1'b1;
                    wr_line          = bus.mem_rsp_data;
                    tag_wr           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = StCompare;
                end
            end
            StFlush: begin
                if (mreq_valid_q) begin
                    if (bus.mem_rsp_ready) begin
                        mreq_valid_d = 1'b0;
                        flush_step   = 1'b1;
                    end
                end else if (valid_q[fidx_q] && dirty_q[fidx_q]) begin
                    mreq_valid_d = 1'b1;
                    mreq_rw_d    = 1'b1;
                    mreq_addr_d  = flush_addr;
                    mreq_data_d  = data_mem[fidx_q];
                end else begin
                    flush_step = 1'b1;
                end
                if (flush_step) begin
                    valid_d[fidx_q] = 1'b0;
                    dirty_d[fidx_q] = 1'b0;
                    if (fidx_q == IDX'(LINES - 1)) begin
                        fidx_d  = '0;
                        state_d = StIdle;
                    end else begin
                        fidx_d = fidx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            valid_q      <= '0;
            dirty_q      <= '0;
            fidx_q       <= '0;
            fpend_q      <= 1'b0;
            ovf_q        <= 1'b0;
            rsp_data_q   <= '0;
            mreq_valid_q <= 1'b0;
            mreq_rw_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            fidx_q       <= fidx_d;
            fpend_q      <= fpend_d;
            ovf_q        <= ovf_d;
            rsp_data_q   <= rsp_data_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_rw_q    <= mreq_rw_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_data_q  <= mreq_data_d;
        end
    end

    // Arrays carry no reset; valid bits alone decide what is readable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_idx] <= wr_line;
        end
        if (tag_wr) begin
            tag_mem[req_idx] <= req_tag;
        end
    end

    assign bus.req_ready     = (state_q == StIdle) && !fpend_q && !bus.flush_req;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_data      = rsp_data;
    assign bus.mem_req_valid = mreq_valid_q;
    assign bus.mem_req_rw    = mreq_rw_q;
    assign bus.mem_req_addr  = mreq_addr_q;
    assign bus.mem_req_data  = mreq_data_q;
    assign bus.flush_busy    = (state_q == StFlush);
    assign bus.ovf           = ovf_q;
endmodule

// File: tb/tb_acc_cache_downstream.sv
// Bench for acc_cache_downstream: flat word-memory model plus a latency-2 backing store.
// A second instance with saturation enabled covers the clamp behaviour.
module tb_acc_cache_downstream;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned LINES   = 16;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    acc_cache_downstream_if #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W)) bus0 ();
    acc_cache_downstream_if #(.DATA_W(DATA_W), .WORDS(WORDS), .ADDR_W(ADDR_W)) bus1 ();

    acc_cache_downstream #(
        .DATA_W(DATA_W), .WORDS(WORDS), .LINES(LINES), .ADDR_W(ADDR_W), .SATURATE(0)
    ) u_dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    acc_cache_downstream #(
        .DATA_W(DATA_W), .WORDS(WORDS), .LINES(LINES), .ADDR_W(ADDR_W), .SATURATE(1)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference: the cache must behave like a flat word memory that starts at zero.
    logic [31:0]  mdl  [int unsigned];
    logic [127:0] bmem [int unsigned];
    bit           mdl_ovf = 1'b0;
    logic [31:0]  exp_q [$];
    logic [31:0]  wb_q  [$];
    logic [31:0]  fill_q[$];

    function automatic logic [31:0] mdl_rd(input int unsigned key);
        return mdl.exists(key) ? mdl[key] : 32'h0;
    endfunction

    task automatic model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        int unsigned key;
        logic [31:0] old;
        logic [32:0] s;
        key = {a[31:2], 2'b00};
        old = mdl_rd(key);
        exp_q.push_back(old);
        case (op)
            2'b01: begin
                s = {1'b0, old} + {1'b0, d};
                if (s[32]) mdl_ovf = 1'b1;
                mdl[key] = s[31:0];
            end
            2'b10:   mdl[key] = 32'h0;
            2'b11:   mdl[key] = d;
            default: ;
        endcase
    endtask

    task automatic model_resync();
        logic [127:0] ln;
        mdl.delete();
        foreach (bmem[k]) begin
            ln = bmem[k];
            for (int w = 0; w < 4; w++) mdl[k + 4 * w] = ln[32*w +: 32];
        end
        mdl_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Backing store: responds MEM_LAT cycles after a request is first seen.
    bit           mbusy = 1'b0;
    int           mcnt  = 0;
    logic         m_rw;
    logic [31:0]  m_a;
    logic [127:0] m_d;
    initial begin
        bus0.mem_rsp_ready = 1'b0;
        bus0.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            bus0.mem_rsp_ready = 1'b0;
            if (!rst) begin
                mbusy = 1'b0;
            end else if (!mbusy) begin
                if (bus0.mem_req_valid) begin
                    mbusy = 1'b1;
                    mcnt  = MEM_LAT;
                    m_rw  = bus0.mem_req_rw;
                    m_a   = bus0.mem_req_addr;
                    m_d   = bus0.mem_req_data;
                end
            end else if (mcnt > 1) begin
                mcnt--;
            end else begin
                mbusy = 1'b0;
                bus0.mem_rsp_ready = 1'b1;
                if (m_rw) begin
                    bmem[m_a] = m_d;
                    wb_q.push_back(m_a);
                end else begin
                    bus0.mem_rsp_data = bmem.exists(m_a) ? bmem[m_a] : '0;
                    fill_q.push_back(m_a);
                end
            end
        end
    end

    // Saturating instance: zero-filled memory answering the cycle after a request.
    initial begin
        bus1.mem_rsp_ready = 1'b0;
        bus1.mem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (bus1.mem_rsp_ready) bus1.mem_rsp_ready = 1'b0;
            else if (rst && bus1.mem_req_valid) bus1.mem_rsp_ready = 1'b1;
        end
    end

    // Per-cycle compare against the model and the memory-request hold rule.
    logic [31:0]  last_rsp = '0;
    logic [31:0]  e_rsp;
    logic         pv = 1'b0, rdy_edge = 1'b0, prw = 1'b0;
    logic [31:0]  pa = '0;
    logic [127:0] pd = '0;
    initial begin
        forever begin
            @(posedge clk);
            rdy_edge = bus0.mem_rsp_ready;
            @(negedge clk);
            if (!rst) begin
                last_rsp = '0;
                pv       = 1'b0;
            end else begin
                if (bus0.rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 1'b1, 1'b0);
                    end else begin
                        e_rsp = exp_q.pop_front();
                        check("rsp_data", bus0.rsp_data, e_rsp);
                        last_rsp = e_rsp;
                    end
                end else begin
                    check("rsp_hold", bus0.rsp_data, last_rsp);
                end
                if (pv && !rdy_edge) begin
                    check("mreq_hold_valid", bus0.mem_req_valid, 1'b1);
                    check("mreq_hold_addr", {bus0.mem_req_rw, bus0.mem_req_addr}, {prw, pa});
                    check("mreq_hold_data", bus0.mem_req_data, pd);
                end
                if (bus0.mem_req_valid) check("mreq_align", bus0.mem_req_addr[3:0], 4'h0);
                pv  = bus0.mem_req_valid;
                prw = bus0.mem_req_rw;
                pa  = bus0.mem_req_addr;
                pd  = bus0.mem_req_data;
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rd);
        int k;
        model_op(op, a, d);
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_op    = op;
        bus0.req_addr  = a;
        bus0.req_data  = d;
        #1;
        k = 0;
        while (!bus0.req_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k >= 200) check("accept_timeout", 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        lat = 1;
        while (!bus0.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) check("rsp_timeout", 1'b0, 1'b1);
        rd = bus0.rsp_data;
        @(negedge clk);
        check("ovf", bus0.ovf, mdl_ovf);
    endtask

    task automatic op1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd);
        int k;
        @(negedge clk);
        bus1.req_valid = 1'b1;
        bus1.req_op    = op;
        bus1.req_addr  = a;
        bus1.req_data  = d;
        #1;
        k = 0;
        while (!bus1.req_ready && k < 200) begin
            @(negedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        k = 0;
        while (!bus1.rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) check("sat_rsp_timeout", 1'b0, 1'b1);
        rd = bus1.rsp_data;
    endtask

    int           lat;
    int           nbusy;
    logic [31:0]  rd;
    logic [127:0] ln;

    initial begin
        bus0.req_valid = 1'b0; bus0.req_op = '0; bus0.req_addr = '0; bus0.req_data = '0;
        bus0.flush_req = 1'b0;
        bus1.req_valid = 1'b0; bus1.req_op = '0; bus1.req_addr = '0; bus1.req_data = '0;
        bus1.flush_req = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_rsp_valid", bus0.rsp_valid, 1'b0);
        check("rst_mem_req_valid", bus0.mem_req_valid, 1'b0);
        check("rst_flush_busy", bus0.flush_busy, 1'b0);
        check("rst_ovf", bus0.ovf, 1'b0);
        check("rst_rsp_data", bus0.rsp_data, 32'h0);
        rst = 1'b1;
        #1;
        check("rst_req_ready", bus0.req_ready, 1'b1);

        // Cold accumulate 5 then 7, then read back.
        do_op(2'b01, 32'h40, 32'd5, lat, rd);
        check("cold_lat", lat, 5);
        check("cold_rsp", rd, 32'd0);
        check("cold_fill_cnt", fill_q.size(), 1);
        check("cold_fill_addr", fill_q[0], 32'h40);
        do_op(2'b01, 32'h40, 32'd7, lat, rd);
        check("hit_lat", lat, 1);
        check("acc2_rsp", rd, 32'd5);
        do_op(2'b00, 32'h40, 32'd0, lat, rd);
        check("acc_read", rd, 32'd12);

        // Read-and-clear.
        do_op(2'b11, 32'h44, 32'd9, lat, rd);
        do_op(2'b10, 32'h44, 32'd0, lat, rd);
        check("rac_rsp", rd, 32'd9);
        do_op(2'b00, 32'h44, 32'd0, lat, rd);
        check("rac_read", rd, 32'd0);

        // Wrapping accumulate sets sticky ovf.
        do_op(2'b11, 32'h48, 32'hFFFF_FFFF, lat, rd);
        do_op(2'b01, 32'h48, 32'd2, lat, rd);
        check("wrap_rsp", rd, 32'hFFFF_FFFF);
        check("wrap_ovf", bus0.ovf, 1'b1);
        do_op(2'b00, 32'h48, 32'd0, lat, rd);
        check("wrap_store", rd, 32'd1);

        // Conflict miss on dirty index 4: write-back of 0x40, then fill of 0x140.
        check("pre_wb_cnt", wb_q.size(), 0);
        do_op(2'b00, 32'h140, 32'd0, lat, rd);
        check("dirty_miss_lat", lat, 8);
        check("wb_cnt", wb_q.size(), 1);
        check("wb_addr", wb_q[0], 32'h40);
        ln = bmem.exists(32'h40) ? bmem[32'h40] : 'x;
        check("wb_data", ln, {32'd0, 32'd1, 32'd0, 32'd12});
        check("fill2_addr", fill_q[1], 32'h140);
        do_op(2'b00, 32'h40, 32'd0, lat, rd);
        check("clean_evict_lat", lat, 5);
        check("refill_rsp", rd, 32'd12);

        // Two dirty lines, then a flush racing a request.
        do_op(2'b01, 32'h100, 32'd3, lat, rd);
        do_op(2'b11, 32'h2F0, 32'hAB, lat, rd);
        @(negedge clk);
        bus0.flush_req = 1'b1;
        bus0.req_valid = 1'b1;
        bus0.req_op    = 2'b00;
        bus0.req_addr  = 32'h100;
        #1;
        check("flush_prio_ready", bus0.req_ready, 1'b0);
        @(negedge clk);
        bus0.flush_req = 1'b0;
        bus0.req_valid = 1'b0;
        nbusy = 0;
        while (bus0.flush_busy && nbusy < 500) begin
            nbusy++;
            @(negedge clk);
        end
        check("flush_cycles", nbusy, 22);
        check("flush_wb_cnt", wb_q.size(), 3);
        check("flush_wb_a", wb_q[1], 32'h100);
        check("flush_wb_b", wb_q[2], 32'h2F0);
        do_op(2'b00, 32'h100, 32'd0, lat, rd);
        check("post_flush_lat", lat, 5);
        check("post_flush_rsp", rd, 32'd3);

        // Reset while waiting for a fill.
        @(negedge clk);
        bus0.req_valid = 1'b1;
        bus0.req_op    = 2'b00;
        bus0.req_addr  = 32'h230;
        @(negedge clk);
        bus0.req_valid = 1'b0;
        @(negedge clk);
        check("alloc_pending", {bus0.mem_req_valid, bus0.mem_req_rw}, 2'b10);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_mreq", bus0.mem_req_valid, 1'b0);
        check("rst_mid_addr", bus0.mem_req_addr, 32'h0);
        check("rst_mid_ovf", bus0.ovf, 1'b0);
        check("rst_mid_rsp", {bus0.rsp_valid, bus0.rsp_data}, 33'h0);
        check("rst_mid_busy", bus0.flush_busy, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_resync();
        #1;
        check("rst_mid_ready", bus0.req_ready, 1'b1);
        do_op(2'b00, 32'h48, 32'd0, lat, rd);
        check("post_rst_lat", lat, 5);
        check("post_rst_rsp", rd, 32'd1);

        // Saturating instance clamps and flags.
        op1(2'b11, 32'h40, 32'hFFFF_FFFF, rd);
        check("sat_first_rsp", rd, 32'h0);
        op1(2'b01, 32'h40, 32'd2, rd);
        check("sat_acc_rsp", rd, 32'hFFFF_FFFF);
        @(negedge clk);
        check("sat_ovf", bus1.ovf, 1'b1);
        op1(2'b00, 32'h40, 32'd0, rd);
        check("sat_store", rd, 32'hFFFF_FFFF);

        repeat (2) @(negedge clk);
        check("rsp_queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/acc_cache_downstream.md
ACC_CACHE_DOWNSTREAM -- requirements
Module: acc_cache_downstream

Interface
REQ-001 Parameter DATA_W, default 32: width of one accumulator word, in bits.
REQ-002 Parameter WORDS, default 4: words per line (power of 2, ≥1); LINE_W = DATA_W*WORDS.
REQ-003 Parameter LINES, default 1024: number of direct-mapped lines (power of 2).
REQ-004 Parameter ADDR_W, default 32: byte-address width; OFS = log2(LINE_W/8), IDX = log2(LINES), TAG = ADDR_W-IDX-OFS.
REQ-005 Parameter SATURATE, default 0: 0 = accumulate modulo 2^DATA_W; 1 = clamp at 2^DATA_W-1.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 req_valid  in  1  client request present.
REQ-009 req_ready  out  1  block accepts request this cycle (asserted only in IDLE).
REQ-010 req_op  in  2  00 read, 01 accumulate, 10 read-and-clear, 11 overwrite.
REQ-011 req_addr  in  ADDR_W  byte address (clientID*DATA_W/8); word select = addr[OFS-1:log2(DATA_W/8)].
REQ-012 req_data  in  DATA_W  operand for accumulate/overwrite.
REQ-013 rsp_valid  out  1  one-cycle pulse at completion of any request.
REQ-014 rsp_data  out  DATA_W  word value before modification (held until next rsp_valid).
REQ-015 mem_req_valid  out  1  downstream memory request.
REQ-016 mem_req_rw  out  1  1 = write-back, 0 = line fill.
REQ-017 mem_req_addr  out  ADDR_W  line-aligned address (low OFS bits zero).
REQ-018 mem_req_data  out  LINE_W  victim line for write-back.
REQ-019 mem_rsp_ready  in  1  memory completed current request (one-cycle pulse).
REQ-020 mem_rsp_data  in  LINE_W  fill data, valid with mem_rsp_ready on a fill.
REQ-021 flush_req  in  1  pulse: write back all dirty lines and invalidate cache.
REQ-022 flush_busy  out  1  flush in progress.
REQ-023 ovf  out  1  sticky: an accumulate wrapped (SATURATE=0) or clamped (SATURATE=1).

Function
REQ-024 States IDLE, COMPARE, WRITE_BACK, ALLOCATE, FLUSH; one transition per clock.
REQ-025 IDLE: req_valid&&req_ready latches op/addr/data, go COMPARE; flush_req in IDLE has priority over a simultaneous req_valid (req_ready low that cycle), go FLUSH.
REQ-026 COMPARE hit (valid && tag match): rsp_valid=1, rsp_data=old word, apply op, go IDLE; hit latency = 1 cycle after acceptance.
REQ-027 Op effects on hit: read none; accumulate word+=req_data, dirty=1; read-and-clear word=0, dirty=1; overwrite word=req_data, dirty=1.
REQ-028 Accumulate computed at DATA_W+1 bits; carry out sets ovf; SATURATE=1 stores all-ones on carry.
REQ-029 COMPARE miss, victim invalid or clean: mem_req_valid=1, rw=0, addr=line of req_addr, go ALLOCATE.
REQ-030 COMPARE miss, victim dirty: mem_req_valid=1, rw=1, addr={victim tag,index,0}, data=victim line, go WRITE_BACK.
REQ-031 WRITE_BACK: hold request stable until mem_rsp_ready; then issue fill (rw=0), go ALLOCATE.
REQ-032 ALLOCATE: hold fill request until mem_rsp_ready; write mem_rsp_data into line, tag=new, valid=1, dirty=0, go COMPARE (then hits).
REQ-033 mem_req_* held constant while mem_req_valid high and mem_rsp_ready low.
REQ-034 FLUSH: index counter 0..LINES-1, flush_busy=1; dirty-valid line issues write-back and waits mem_rsp_ready; every line then valid=0, dirty=0; after index LINES-1 go IDLE; flush_busy drops that cycle.
REQ-035 flush_req outside IDLE is latched and serviced on next return to IDLE before any new request.
REQ-036 Clean/invalid lines in FLUSH take one cycle each; full flush of a clean cache = LINES cycles.

Reset
REQ-037 rst low: state IDLE, all valid/dirty bits 0, flush counter 0, pending flush 0, ovf 0, rsp_data 0; all outputs 0 except req_ready=1 after release.
REQ-038 Reset mid-transaction abandons it with no response; data array contents undefined, readable only after refill.

Verification
REQ-039 Accumulate 5 then 7 to addr 0x40 (cold, mem fill zeros) -> one fill to 0x40; rsp_data 0 then 5; read returns 12.
REQ-040 DATA_W=32, SATURATE=0: overwrite 0xFFFFFFFF, accumulate 2 -> stored 1, ovf=1; SATURATE=1 -> stored 0xFFFFFFFF, ovf=1.
REQ-041 Dirty line at index 0 tag A, request index 0 tag B -> write-back to tag A address with dirty data, then fill of B, then rsp_valid.
REQ-042 Read-and-clear word holding 9 -> rsp_data 9; subsequent read returns 0.
REQ-043 Flush with 2 dirty lines, LINES=16 -> exactly 2 write-backs, flush_busy high until index 15, next access misses.
REQ-044 rst asserted in ALLOCATE -> all outputs reset immediately; first post-reset request misses.
